master_port_decoder: RTL and testbench
======================================

# master_port_decoder

Master-side front end of the interconnect, one instance per bus master. It accepts a single transaction from its master, decodes the address into a one-hot slave request, and flags the first request cycle so the slave-side arbiters can tell a new transaction from a continuing one. It then waits for the selected slave's acknowledge, which arrives only while that slave's arbiter has selected this master, and returns read data or an error response to the master. Undecodable addresses and slaves that never acknowledge terminate with an error, so a master can never hang the bus.

## Interface

Parameters:

- NUM_SLAVES, 4, number of slave ports; slave index 0..NUM_SLAVES-1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- SEL_LSB, 28, lowest address bit of the slave index field; index = i_Addr[ADDR_W-1:SEL_LSB].
- TIMEOUT, 255, cycles in REQ without an acknowledge before an error response; range 1..65535.

Ports:

- i_Clk  in  1  clock; all logic is rising-edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Req  in  1  master request; held high with all master fields stable until o_Ack.
- i_We  in  1  1 = write, 0 = read.
- i_Addr  in  ADDR_W  transaction address.
- i_WData  in  DATA_W  write data.
- i_ByteEn  in  DATA_W/8  byte enables.
- o_Ack  out  1  one-cycle completion pulse to the master.
- o_Err  out  1  error flag, valid only with o_Ack.
- o_RData  out  DATA_W  read data, valid only with o_Ack.
- o_Slv_Req  out  NUM_SLAVES  one-hot request to the slave arbiters.
- o_Slv_NewTransaction  out  1  high only in the first cycle of a request.
- o_Slv_We, o_Slv_Addr, o_Slv_WData, o_Slv_ByteEn  out  1/ADDR_W/DATA_W/DATA_W/8  registered copies of the master fields.
- i_Slv_Ack  in  NUM_SLAVES  per-slave acknowledge.
- i_Slv_RData  in  NUM_SLAVES*DATA_W  per-slave read data; slave k occupies bits [k*DATA_W +: DATA_W].

## Operation

- The FSM has three states: IDLE, REQ and RESP. The reset state is IDLE.
- **IDLE, with i_Req = 1:**
  - All master fields are registered into the o_Slv_* registers.
  - The slave index is computed and the timeout counter is cleared.
  - If index < NUM_SLAVES, the next state is REQ. Otherwise the captured error flag is set and the next state is RESP, with no slave request ever issued.
- **REQ:**
  - o_Slv_Req[index] = 1 and all other bits are 0.
  - o_Slv_NewTransaction = 1 only in the first REQ cycle.
  - On i_Slv_Ack[index] = 1:
    - the read data slice for that slave is captured;
    - for a write, the captured read data is 0;
    - the error flag is cleared;
    - the next state is RESP.
  - An acknowledge on any other bit is ignored.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and no acknowledge is present, the error flag is set, the captured read data is set to 0, and the next state is RESP.
  - An acknowledge arriving in the same cycle as the timeout takes priority and the transaction succeeds.
- **RESP:**
  - o_Ack = 1, o_Err = the captured error flag, o_RData = the captured data.
  - o_Slv_Req = 0.
  - The next state is always IDLE; i_Req is not sampled in RESP.
- All outputs are registered or derived from state only. There is no combinational path from any input to any output.
- i_Req falling in REQ is a master protocol violation. The block completes the transaction anyway.

## Timing

- **Reset values:** o_Ack = 0, o_Err = 0, o_RData = 0, o_Slv_Req = 0, o_Slv_NewTransaction = 0, o_Slv_We = 0, o_Slv_Addr = 0, o_Slv_WData = 0, o_Slv_ByteEn = 0. The state is IDLE and the counter is 0.
- **Reset mid-transaction:** reset takes effect at the next edge. All outputs show their reset values in the following cycle, and any pending response is discarded.
- **Successful transaction:**
  - Cycle 0: i_Req is sampled in IDLE.
  - Cycle 1: first REQ cycle, with o_Slv_NewTransaction = 1.
  - Cycle k (k ≥ 1): i_Slv_Ack is seen.
  - Cycle k+1: o_Ack.
  - Minimum latency from request to o_Ack is 2 cycles.
- **Decode error:** o_Ack and o_Err in cycle 1.
- **Timeout:** with no acknowledge, the REQ phase lasts exactly TIMEOUT cycles (cycles 1..TIMEOUT). o_Ack and o_Err follow in cycle TIMEOUT+1.
- **Back-to-back transactions:** the master drops i_Req or presents a new transaction in the cycle after o_Ack. Throughput is at most one transaction per 3 cycles.
  - A new request is accepted in IDLE (cycle k+2). Its first REQ cycle is cycle k+3.
  - Every transaction re-asserts o_Slv_NewTransaction, including a repeat to the same slave. This lets the arbiter re-arbitrate between transactions.

## Test plan

- **Read, slave 2:** after reset, i_Addr = 0x2000_0010, i_We = 0.
  - Expect o_Slv_Req = 4'b0100 and o_Slv_NewTransaction = 1 in cycle 1 only.
  - Slave 2 acknowledges in cycle 3 with i_Slv_RData slice = 0xDEAD_BEEF.
  - Expect o_Ack = 1, o_Err = 0, o_RData = 0xDEAD_BEEF in cycle 4.
- **Write, slave 0:** i_WData = 0x1234_5678, i_ByteEn = 4'b0011, immediate acknowledge in cycle 1.
  - Expect o_Slv_WData = 0x1234_5678 and o_Slv_ByteEn = 4'b0011.
  - Expect o_Ack in cycle 2 with o_RData = 0.
- **Decode error:** i_Addr = 0x7000_0000 with NUM_SLAVES = 4.
  - Expect o_Slv_Req to stay 0 throughout.
  - Expect o_Ack = 1, o_Err = 1 in cycle 1.
- **Timeout:** TIMEOUT = 8, read from slave 1, which never acknowledges.
  - Expect o_Slv_Req[1] high for exactly 8 cycles.
  - Expect o_Ack = 1, o_Err = 1, o_RData = 0 in cycle 9.
  - Repeat with the acknowledge arriving in cycle 8: expect success.
- **Wrong-slave acknowledge, then back-to-back:** during a request to slave 3, pulse i_Slv_Ack[0].
  - Expect no o_Ack.
  - Then send a second transaction to slave 3 right after the first completes. Expect a new o_Slv_NewTransaction pulse.
- **Reset during REQ:** assert i_Rst in cycle 2.
  - Expect all outputs at their reset values from cycle 3.
  - Expect no o_Ack.
  - Expect the next request to complete normally.

Source files
------------

// File: rtl/master_port_decoder.sv
// Master-side interconnect front end: decodes one master transaction into a one-hot
// slave request, waits for that slave's acknowledge (or a timeout) and answers the master.
module master_port_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_Req,
    input  logic                         i_We,
    input  logic [ADDR_W-1:0]            i_Addr,
    input  logic [DATA_W-1:0]            i_WData,
    input  logic [DATA_W/8-1:0]          i_ByteEn,
    output logic                         o_Ack,
    output logic                         o_Err,
    output logic [DATA_W-1:0]            o_RData,
    output logic [NUM_SLAVES-1:0]        o_Slv_Req,
    output logic                         o_Slv_NewTransaction,
    output logic                         o_Slv_We,
    output logic [ADDR_W-1:0]            o_Slv_Addr,
    output logic [DATA_W-1:0]            o_Slv_WData,
    output logic [DATA_W/8-1:0]          o_Slv_ByteEn,
    input  logic [NUM_SLAVES-1:0]        i_Slv_Ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_Slv_RData
);

    localparam int          FIELD_W = ADDR_W - SEL_LSB;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  state;
    logic [15:0]             cnt;
    logic [FIELD_W-1:0]      field;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic [NUM_SLAVES-1:0]   ack_hit;
    logic [DATA_W-1:0]       rsel;

    assign field = i_Addr[ADDR_W-1:SEL_LSB];

    // An index outside the slave range leaves the one-hot vector empty.
    always_comb begin
        dec_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            dec_onehot[k] = (field == FIELD_W'(k));
    end

    // o_Slv_Req is non-zero only in REQ, so it doubles as the ack filter and data select.
    assign ack_hit = i_Slv_Ack & o_Slv_Req;

    always_comb begin
        rsel = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (o_Slv_Req[k])
                rsel = rsel | i_Slv_RData[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            o_Ack                <= 1'b0;
            o_Err                <= 1'b0;
            o_RData              <= '0;
            o_Slv_Req            <= '0;
            o_Slv_NewTransaction <= 1'b0;
            o_Slv_We             <= 1'b0;
            o_Slv_Addr           <= '0;
            o_Slv_WData          <= '0;
            o_Slv_ByteEn         <= '0;
        end else begin
            o_Ack                <= 1'b0;
            o_Slv_NewTransaction <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Req) begin
                        o_Slv_We     <= i_We;
                        o_Slv_Addr   <= i_Addr;
                        o_Slv_WData  <= i_WData;
                        o_Slv_ByteEn <= i_ByteEn;
                        cnt          <= '0;
                        if (|dec_onehot) begin
                            o_Slv_Req            <= dec_onehot;
                            o_Slv_NewTransaction <= 1'b1;
                            state                <= REQ;
                        end else begin
                            o_Err   <= 1'b1;
                            o_RData <= '0;
                            o_Ack   <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                REQ: begin
                    // A late acknowledge still wins over a timeout in the same cycle.
                    if (|ack_hit) begin
                        o_RData   <= o_Slv_We ? '0 : rsel;
                        o_Err     <= 1'b0;
                        o_Ack     <= 1'b1;
                        o_Slv_Req <= '0;
                        state     <= RESP;
                    end else if (cnt == TO_LAST) begin
                        o_RData   <= '0;
                        o_Err     <= 1'b1;
                        o_Ack     <= 1'b1;
                        o_Slv_Req <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    o_Err   <= 1'b0;
                    o_RData <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_port_decoder.sv
// Directed bench for master_port_decoder: a vector table of whole transactions checked
// cycle by cycle, plus hand-written reset sequences.
module tb_master_port_decoder;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req, we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   be;
    logic              ack, err;
    logic [DW-1:0]     rdata;
    logic [NS-1:0]     slv_req;
    logic              slv_new, slv_we;
    logic [AW-1:0]     slv_addr;
    logic [DW-1:0]     slv_wdata;
    logic [DW/8-1:0]   slv_be;
    logic [NS-1:0]     slv_ack;
    logic [NS*DW-1:0]  slv_rdata;

    int checks = 0;
    int errors = 0;

    master_port_decoder #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(28), .TIMEOUT(TO)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_We(we), .i_Addr(addr), .i_WData(wdata),
        .i_ByteEn(be), .o_Ack(ack), .o_Err(err), .o_RData(rdata), .o_Slv_Req(slv_req),
        .o_Slv_NewTransaction(slv_new), .o_Slv_We(slv_we), .o_Slv_Addr(slv_addr),
        .o_Slv_WData(slv_wdata), .o_Slv_ByteEn(slv_be), .i_Slv_Ack(slv_ack),
        .i_Slv_RData(slv_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        int            ack_cyc;     // cycle the target slave acknowledges, 0 = never
        int            bad_ack_cyc; // cycle slave 0 acknowledges spuriously, 0 = never
        logic [31:0]   sdata;       // target slave read data
        int            exp_done;    // cycle o_Ack is expected
        logic          exp_err;
        logic [31:0]   exp_rdata;
        logic [3:0]    exp_req;     // 0 = decode error, no request
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_slv_req"}, 64'(slv_req), 64'd0);
        chk({tag, "_slv_new"}, 64'(slv_new), 64'd0);
        chk({tag, "_slv_we"}, 64'(slv_we), 64'd0);
        chk({tag, "_slv_addr"}, 64'(slv_addr), 64'd0);
        chk({tag, "_slv_wdata"}, 64'(slv_wdata), 64'd0);
        chk({tag, "_slv_be"}, 64'(slv_be), 64'd0);
    endtask

    // Starts in the cycle after the previous transaction's o_Ack (cycle 0 of this one).
    task automatic run_vec(input int n, input vec_t v);
        string t;
        logic  in_req;
        t = $sformatf("v%0d", n);
        @(posedge clk); #1;
        chk({t, "_c0_ack"}, 64'(ack), 64'd0);
        chk({t, "_c0_req"}, 64'(slv_req), 64'd0);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be; slv_ack = '0;
        for (int k = 0; k < NS; k++) slv_rdata[k*DW +: DW] = 32'hC0DE_0000 + 32'(k);
        for (int k = 0; k < NS; k++) if (v.exp_req[k]) slv_rdata[k*DW +: DW] = v.sdata;
        for (int c = 1; c <= v.exp_done; c++) begin
            @(posedge clk); #1;
            in_req = (v.exp_req != 4'd0) && (c < v.exp_done);
            chk($sformatf("%s_c%0d_slv_req", t, c), 64'(slv_req), in_req ? 64'(v.exp_req) : 64'd0);
            chk($sformatf("%s_c%0d_new", t, c), 64'(slv_new), 64'(in_req && c == 1));
            chk($sformatf("%s_c%0d_ack", t, c), 64'(ack), 64'(c == v.exp_done));
            if (c == 1) begin
                chk({t, "_slv_we"}, 64'(slv_we), 64'(v.we));
                chk({t, "_slv_addr"}, 64'(slv_addr), 64'(v.addr));
                chk({t, "_slv_wdata"}, 64'(slv_wdata), 64'(v.wdata));
                chk({t, "_slv_be"}, 64'(slv_be), 64'(v.be));
            end
            if (c == v.exp_done) begin
                chk({t, "_err"}, 64'(err), 64'(v.exp_err));
                chk({t, "_rdata"}, 64'(rdata), 64'(v.exp_rdata));
            end
            slv_ack = '0;
            if (c == v.ack_cyc) slv_ack = v.exp_req;
            if (c == v.bad_ack_cyc) slv_ack[0] = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            req = 1'b0; slv_ack = '0;
            chk($sformatf("%s_idle%0d_ack", tag, c), 64'(ack), 64'd0);
            chk($sformatf("%s_idle%0d_req", tag, c), 64'(slv_req), 64'd0);
        end
    endtask

    initial begin
        //          we    addr           wdata          be       ack bad sdata          done err exp_rdata     req
        vecs[0] = '{1'b0, 32'h2000_0010, 32'h0,         4'b0000, 3,  0,  32'hDEAD_BEEF, 4,   0,  32'hDEAD_BEEF, 4'b0100};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 1,  0,  32'h55AA_55AA, 2,   0,  32'h0,         4'b0001};
        vecs[2] = '{1'b0, 32'h7000_0000, 32'h0,         4'b1111, 0,  0,  32'h0,         1,   1,  32'h0,         4'b0000};
        vecs[3] = '{1'b0, 32'h4000_0000, 32'h0,         4'b1111, 0,  0,  32'h0,         1,   1,  32'h0,         4'b0000};
        vecs[4] = '{1'b0, 32'h1000_0004, 32'h0,         4'b1111, 0,  0,  32'h1111_2222, 9,   1,  32'h0,         4'b0010};
        vecs[5] = '{1'b0, 32'h1000_0008, 32'h0,         4'b1111, 8,  0,  32'h0BAD_F00D, 9,   0,  32'h0BAD_F00D, 4'b0010};
        vecs[6] = '{1'b0, 32'h3000_0100, 32'h0,         4'b1111, 4,  2,  32'h1357_9BDF, 5,   0,  32'h1357_9BDF, 4'b1000};
        vecs[7] = '{1'b1, 32'h3000_0104, 32'hCAFE_F00D, 4'b1111, 2,  0,  32'h2468_ACE0, 3,   0,  32'h0,         4'b1000};
        vecs[8] = '{1'b0, 32'hF000_0000, 32'h0,         4'b0001, 0,  0,  32'h0,         1,   1,  32'h0,         4'b0000};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        slv_ack = '0; slv_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        idle_cycles(2, "post_table");

        // Reset asserted in cycle 2 of a read to slave 2 that is never acknowledged.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h2000_0020; wdata = 32'h0; be = 4'b1111;
        @(posedge clk); #1;
        chk("rst_mid_c1_req", 64'(slv_req), 64'b0100);
        chk("rst_mid_c1_new", 64'(slv_new), 64'd1);
        @(posedge clk); #1;
        chk("rst_mid_c2_req", 64'(slv_req), 64'b0100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst_mid_c3");
        rst = 1'b0; req = 1'b0;
        idle_cycles(TO + 2, "rst_mid");

        run_vec(20, vecs[0]);
        run_vec(21, vecs[1]);
        idle_cycles(1, "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
